// File: rtl/csr_access_unit.sv
// csr_access_unit: EXU-to-CSR-file initiator; sequences read, single-cycle commit and WBU response for one CSR-class instruction.
// Ports: clk/rst (sync, active-high); in_* request with valid/ready; csr_raddr/csr_rdata read port;
// csr_commit strobe with csr_waddr/csr_wdata/csr_wen/csr_is_ecall/csr_is_mret/csr_pc; out_* result with valid/ready.
// Optional macro CSR_ADDR_CHECK_EN: flags CSR ops outside 0x300/0x305/0x341/0x342 as illegal.
module csr_access_unit #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_csr_addr,
  input  logic [4:0]            in_rs1_idx,
  input  logic [DATA_WIDTH-1:0] in_rs1_val,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  in_is_ecall,
  input  logic                  in_is_mret,
  output logic [ADDR_WIDTH-1:0] csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_commit,
  output logic [ADDR_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_wen,
  output logic                  csr_is_ecall,
  output logic                  csr_is_mret,
  output logic [DATA_WIDTH-1:0] csr_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rd_data,
  output logic                  out_rd_wen,
  output logic                  out_redirect,
  output logic [DATA_WIDTH-1:0] out_redirect_pc,
  output logic                  out_illegal
);
  typedef enum logic [1:0] {IDLE, READ, COMMIT, RESP} state_t;
  state_t                state;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [4:0]            idx_q;
  logic [DATA_WIDTH-1:0] val_q, pc_q, old_q, src, wdata;
  logic                  ecall_q, mret_q, csr_op, illegal, wen_c;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      val_q    <= '0;
      pc_q     <= '0;
      old_q    <= '0;
      ecall_q  <= 1'b0;
      mret_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          funct3_q <= in_funct3;
          addr_q   <= in_csr_addr;
          idx_q    <= in_rs1_idx;
          val_q    <= in_rs1_val;
          pc_q     <= in_pc;
          ecall_q  <= in_is_ecall;
          // ecall wins over mret, so mret is masked at capture
          mret_q   <= in_is_mret & ~in_is_ecall;
          state    <= READ;
        end
        READ: begin
          old_q <= csr_rdata;
          state <= COMMIT;
        end
        COMMIT: state <= RESP;
        RESP: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign src    = funct3_q[2] ? DATA_WIDTH'(idx_q) : val_q;
  assign csr_op = ~ecall_q & ~mret_q & (funct3_q[1:0] != 2'b00);
`ifdef CSR_ADDR_CHECK_EN
  assign illegal = csr_op & ~(addr_q == ADDR_WIDTH'(12'h300) || addr_q == ADDR_WIDTH'(12'h305) ||
                              addr_q == ADDR_WIDTH'(12'h341) || addr_q == ADDR_WIDTH'(12'h342));
`else
  assign illegal = 1'b0;
`endif
  // set/clear with rs1=x0 (or zimm=0) must not write, so gate on the index field
  assign wen_c = csr_op & ~illegal & (funct3_q[1:0] == 2'b01 || idx_q != 5'd0);
  always_comb begin
    wdata = funct3_q[1:0] == 2'b01 ? src :
            funct3_q[1:0] == 2'b10 ? (old_q | src) :
            funct3_q[1:0] == 2'b11 ? (old_q & ~src) : old_q;
  end
  assign in_ready        = state == IDLE;
  assign csr_raddr       = addr_q;
  // rst gates the strobe combinationally so a reset during COMMIT never commits
  assign csr_commit      = state == COMMIT && !rst;
  assign csr_waddr       = addr_q;
  assign csr_wdata       = wdata;
  assign csr_wen         = csr_commit & wen_c;
  assign csr_is_ecall    = ecall_q & (state == READ || state == COMMIT);
  assign csr_is_mret     = mret_q & (state == READ || state == COMMIT);
  assign csr_pc          = pc_q;
  assign out_valid       = state == RESP;
  assign out_rd_data     = illegal ? '0 : old_q;
  assign out_rd_wen      = csr_op & ~illegal;
  assign out_redirect    = ecall_q | mret_q;
  assign out_redirect_pc = (ecall_q | mret_q) ? old_q : '0;
  assign out_illegal     = illegal;
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed and random CSR instructions against a CSR-file model and a reference result model.
module tb_csr_access_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  in_funct3 = '0;
  logic [11:0] in_csr_addr = '0;
  logic [4:0]  in_rs1_idx = '0;
  logic [31:0] in_rs1_val = '0, in_pc = '0;
  logic        in_is_ecall = 1'b0, in_is_mret = 1'b0;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata, csr_pc;
  logic        csr_commit, csr_wen, csr_is_ecall, csr_is_mret;
  logic        out_valid, out_ready = 1'b0, out_rd_wen, out_redirect, out_illegal;
  logic [31:0] out_rd_data, out_redirect_pc;
  int          checks = 0, failures = 0;
  // CSR file model: mstatus, mtvec, mepc, mcause; all other addresses read 0 and drop writes
  logic [31:0] file_r [4];
  logic [31:0] ref_r [4];
  logic        pre_en = 1'b0;
  logic [1:0]  pre_i = '0;
  logic [31:0] pre_v = '0;
  int          commit_cnt = 0;
  csr_access_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_csr_addr(in_csr_addr), .in_rs1_idx(in_rs1_idx), .in_rs1_val(in_rs1_val), .in_pc(in_pc),
    .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_commit(csr_commit), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .csr_is_ecall(csr_is_ecall), .csr_is_mret(csr_is_mret), .csr_pc(csr_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_rd_data(out_rd_data), .out_rd_wen(out_rd_wen), .out_redirect(out_redirect),
    .out_redirect_pc(out_redirect_pc), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  function automatic int slot(input logic [11:0] a);
    return a == 12'h300 ? 0 : a == 12'h305 ? 1 : a == 12'h341 ? 2 : a == 12'h342 ? 3 : -1;
  endfunction
  always_comb begin
    csr_rdata = 32'h0;
    if (csr_is_ecall) csr_rdata = file_r[1];
    else if (csr_is_mret) csr_rdata = file_r[2];
    else if (slot(csr_raddr) >= 0) csr_rdata = file_r[slot(csr_raddr)];
  end
  always @(posedge clk) begin
    if (pre_en) file_r[pre_i] <= pre_v;
    if (csr_commit) begin
      commit_cnt <= commit_cnt + 1;
      if (csr_is_ecall) begin
        file_r[2] <= csr_pc;
        file_r[3] <= 32'd11;
      end else if (csr_wen && slot(csr_waddr) >= 0) file_r[slot(csr_waddr)] <= csr_wdata;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic preset(input logic [1:0] i, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_i = i; pre_v = v; ref_r[i] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask
  task automatic accept(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                        input logic [31:0] val, input logic [31:0] pc, input logic e, input logic m);
    int n = 0;
    in_valid = 1'b1; in_funct3 = f3; in_csr_addr = a; in_rs1_idx = idx;
    in_rs1_val = val; in_pc = pc; in_is_ecall = e; in_is_mret = m;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_funct3 = 3'($urandom); in_csr_addr = 12'($urandom); in_rs1_idx = 5'($urandom);
    in_rs1_val = $urandom; in_pc = $urandom; in_is_ecall = 1'($urandom); in_is_mret = 1'($urandom);
  endtask
  task automatic do_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                       input logic [31:0] val, input logic [31:0] pc, input logic e, input logic m,
                       input int hold);
    logic [31:0] old, src, wd, rd;
    logic        me, is_op, ill, w;
    me    = m && !e;
    old   = e ? ref_r[1] : me ? ref_r[2] : (slot(a) >= 0 ? ref_r[slot(a)] : 32'h0);
    src   = f3[2] ? {27'h0, idx} : val;
    is_op = !e && !me && f3[1:0] != 2'b00;
`ifdef CSR_ADDR_CHECK_EN
    ill = is_op && slot(a) < 0;
`else
    ill = 1'b0;
`endif
    w  = is_op && !ill && (f3[1:0] == 2'b01 || idx != 0);
    wd = f3[1:0] == 2'b01 ? src : f3[1:0] == 2'b10 ? (old | src) : (old & ~src);
    accept(f3, a, idx, val, pc, e, m);
    chk("read_in_ready", 32'(in_ready), 32'd0);
    chk("read_commit", 32'(csr_commit), 32'd0);
    chk("read_out_valid", 32'(out_valid), 32'd0);
    chk("read_raddr", 32'(csr_raddr), 32'(a));
    chk("read_ecall", 32'(csr_is_ecall), 32'(e));
    chk("read_mret", 32'(csr_is_mret), 32'(me));
    @(negedge clk);
    chk("commit_strobe", 32'(csr_commit), 32'd1);
    chk("commit_out_valid", 32'(out_valid), 32'd0);
    chk("commit_waddr", 32'(csr_waddr), 32'(a));
    chk("commit_wen", 32'(csr_wen), 32'(w));
    if (w) chk("commit_wdata", csr_wdata, wd);
    chk("commit_ecall", 32'(csr_is_ecall), 32'(e));
    chk("commit_mret", 32'(csr_is_mret), 32'(me));
    chk("commit_pc", csr_pc, pc);
    @(negedge clk);
    rd = ill ? 32'h0 : old;
    chk("resp_valid", 32'(out_valid), 32'd1);
    chk("resp_commit", 32'(csr_commit), 32'd0);
    chk("resp_rd_data", out_rd_data, rd);
    chk("resp_rd_wen", 32'(out_rd_wen), 32'(is_op && !ill));
    chk("resp_redirect", 32'(out_redirect), 32'(e || me));
    if (e || me) chk("resp_redirect_pc", out_redirect_pc, old);
    chk("resp_illegal", 32'(out_illegal), 32'(ill));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_rd_data", out_rd_data, rd);
      chk("hold_redirect", 32'(out_redirect), 32'(e || me));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd1);
    if (e) begin
      ref_r[2] = pc;
      ref_r[3] = 32'd11;
    end else if (w && slot(a) >= 0) ref_r[slot(a)] = wd;
  endtask
  initial begin
    int      cnt;
    logic [2:0]  f3;
    logic [11:0] a;
    logic [11:0] addrs [5] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};
    for (int i = 0; i < 4; i++) ref_r[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_commit", 32'(csr_commit), 32'd0);
    chk("rst_wen", 32'(csr_wen), 32'd0);
    chk("rst_flags", {28'h0, csr_is_ecall, csr_is_mret, out_rd_wen, out_redirect}, 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    chk("rst_rd_data", out_rd_data, 32'h0);
    chk("rst_wdata", csr_wdata, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) preset(2'(i), 32'h0);
    do_op(3'b001, 12'h305, 5'd5, 32'h8000_0100, 32'h0, 1'b0, 1'b0, 0);
    preset(2'd0, 32'h1800);
    do_op(3'b010, 12'h300, 5'd0, 32'hffff_ffff, 32'h0, 1'b0, 1'b0, 0);
    do_op(3'b110, 12'h300, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    preset(2'd3, 32'hb);
    do_op(3'b011, 12'h342, 5'd7, 32'h3, 32'h0, 1'b0, 1'b0, 1);
    do_op(3'b000, 12'h000, 5'd0, 32'h0, 32'h8000_0040, 1'b1, 1'b0, 2);
    do_op(3'b000, 12'h302, 5'd0, 32'h0, 32'h8000_0200, 1'b0, 1'b1, 0);
    do_op(3'b000, 12'h000, 5'd0, 32'h0, 32'h1234_0000, 1'b1, 1'b1, 0);
    do_op(3'b100, 12'h300, 5'd9, 32'h55, 32'h0, 1'b0, 1'b0, 0);
    do_op(3'b001, 12'h341, 5'd2, 32'hcafe_0000, 32'h0, 1'b0, 1'b0, 5);
    do_op(3'b001, 12'h341, 5'd2, 32'h0000_beef, 32'h0, 1'b0, 1'b0, 0);
    do_op(3'b001, 12'h7C0, 5'd1, 32'h1357_9bdf, 32'h0, 1'b0, 1'b0, 0);
    do_op(3'b111, 12'h7C0, 5'd4, 32'h0, 32'h0, 1'b0, 1'b0, 0);
    cnt = commit_cnt;
    accept(3'b001, 12'h300, 5'd1, 32'hdead_beef, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_commit", 32'(csr_commit), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_no_commit", 32'(commit_cnt), 32'(cnt));
    chk("rst_mid_mstatus", file_r[0], ref_r[0]);
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = addrs[$urandom_range(0, 4)];
      do_op(f3, a, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4));
    end
    for (int i = 0; i < 4; i++) chk("final_csr", file_r[i], ref_r[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
